// File: rtl/pipelined_carry_gen.sv
// Pipelined ripple carry generator: per 2-bit group propagate/generate feeding a
// CARRY4-style chain, split into NSTAGES registered stages with operand/result skew.
module pipelined_carry_gen #(
  parameter int WIDTH            = 32,
  parameter int SLICES_PER_STAGE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               c_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic [WIDTH/2-1:0] c_out,
  output logic               co
);

  localparam int SW      = 8 * SLICES_PER_STAGE;
  localparam int GPS     = SW / 2;
  localparam int NSTAGES = WIDTH / SW;
  localparam int NGROUPS = WIDTH / 2;
  localparam int LAST    = NSTAGES - 1;

  if (SLICES_PER_STAGE < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_width
    $error("pipelined_carry_gen: WIDTH must be a nonzero multiple of 8*SLICES_PER_STAGE");
  end

  // Handshake: a beat transfers on a port when valid & ready are both high at
  // the rising edge. One global enable advances (or holds) every stage at once,
  // so in_ready is high whenever the output register is empty or being drained.
  logic             adv;
  logic [WIDTH-1:0] bb0;
  logic             cin0;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bb0      = sub ? ~b : b;
  assign cin0     = sub | c_in;

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    localparam int UW = WIDTH - SW * s;  // operand bits not yet consumed

    logic [UW-1:0]          a_i, bb_i;
    logic                   ci, v_i;
    logic [SW-1:0]          sum_s;
    logic [GPS-1:0]         cg_s;
    logic [SW*(s+1)-1:0]    sum_n, sum_q;
    logic [GPS*(s+1)-1:0]   cg_n, cg_q;
    logic                   v_q;

    if (s == 0) begin : g_src
      assign a_i   = a;
      assign bb_i  = bb0;
      assign ci    = cin0;
      assign v_i   = in_valid;
      assign sum_n = sum_s;
      assign cg_n  = cg_s;
    end else begin : g_src
      assign a_i   = g_stage[s-1].g_skew.a_q;
      assign bb_i  = g_stage[s-1].g_skew.bb_q;
      assign ci    = g_stage[s-1].cg_q[GPS*s-1];
      assign v_i   = g_stage[s-1].v_q;
      assign sum_n = {sum_s, g_stage[s-1].sum_q};
      assign cg_n  = {cg_s, g_stage[s-1].cg_q};
    end

    // Low SW bits of the pending operands form this stage's slices.
    always_comb begin : comb_slice
      logic c, cm, p0, p1, gen, prop;
      c     = ci;
      cm    = 1'b0;
      p0    = 1'b0;
      p1    = 1'b0;
      gen   = 1'b0;
      prop  = 1'b0;
      sum_s = '0;
      cg_s  = '0;
      for (int g = 0; g < GPS; g++) begin
        p0   = a_i[2*g] ^ bb_i[2*g];
        p1   = a_i[2*g+1] ^ bb_i[2*g+1];
        prop = p0 & p1;
        gen  = (a_i[2*g+1] & bb_i[2*g+1]) | (p1 & a_i[2*g] & bb_i[2*g]);
        cm   = (a_i[2*g] & bb_i[2*g]) | (p0 & c);
        sum_s[2*g]   = p0 ^ c;
        sum_s[2*g+1] = p1 ^ cm;
        c        = gen | (prop & c);
        cg_s[g]  = c;
      end
    end

    if (s < LAST) begin : g_skew
      logic [UW-SW-1:0] a_q, bb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bb_q <= '0;
        end else if (adv) begin
          a_q  <= a_i[UW-1:SW];
          bb_q <= bb_i[UW-1:SW];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        cg_q  <= '0;
      end else if (adv) begin
        v_q   <= v_i;
        sum_q <= sum_n;
        cg_q  <= cg_n;
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].sum_q;
  assign c_out     = g_stage[LAST].cg_q;
  assign co        = c_out[NGROUPS-1];

endmodule
